// File: rtl/ascon_block_loader_pkg.sv
// ascon_pack: types and constants shared by the Ascon block loader.
//   loader_state_t  : loader FSM states
//   ASCON_PAD_BYTE  : byte appended after the last message byte
package ascon_pack;
  typedef enum logic [1:0] {S_FILL, S_HOLD, S_PADBLK} loader_state_t;
  localparam logic [7:0] ASCON_PAD_BYTE = 8'h80;
endpackage

// File: rtl/ascon_block_loader_if.sv
// ascon_block_loader_if: beat stream in, block stream out.
//   valid_i/ready_o/data_i/last_i/nbytes_i : 32-bit beat side (sender -> loader)
//   block_valid_o/block_ready_i/en_o        : block handshake and register enable
//   data_o/last_o/pad_o                     : assembled block and its flags
// master = beat sender / block consumer, slave = loader.
interface ascon_block_loader_if #(
  parameter int beat_w_g  = 32,
  parameter int block_w_g = 128
);
  localparam int NB_W = $clog2(beat_w_g/8) + 1;

  logic                 valid_i;
  logic                 ready_o;
  logic [beat_w_g-1:0]  data_i;
  logic                 last_i;
  logic [NB_W-1:0]      nbytes_i;
  logic                 block_valid_o;
  logic                 block_ready_i;
  logic                 en_o;
  logic [block_w_g-1:0] data_o;
  logic                 last_o;
  logic                 pad_o;

  modport master (
    output valid_i, data_i, last_i, nbytes_i, block_ready_i,
    input  ready_o, block_valid_o, en_o, data_o, last_o, pad_o
  );
  modport slave (
    input  valid_i, data_i, last_i, nbytes_i, block_ready_i,
    output ready_o, block_valid_o, en_o, data_o, last_o, pad_o
  );
endinterface

// File: rtl/ascon_block_loader_beat_pad.sv
// ascon_beat_pad: combinational padding of one beat.
//   data_i   : beat, byte 0 in the MSBs
//   last_i   : beat is the final message beat (padding applies only then)
//   nbytes_i : valid bytes in a last beat; 0 or > bytes-per-beat means a full beat
//   data_o   : beat with bytes past nbytes_i cleared and the pad byte inserted
//   spill_o  : last beat was full, so the pad byte belongs to the next slot
module ascon_beat_pad
  import ascon_pack::*;
#(
  parameter int beat_w_g = 32
) (
  input  logic [beat_w_g-1:0]          data_i,
  input  logic                         last_i,
  input  logic [$clog2(beat_w_g/8):0]  nbytes_i,
  output logic [beat_w_g-1:0]          data_o,
  output logic                         spill_o
);
  localparam int B    = beat_w_g/8;
  localparam int NB_W = $clog2(B) + 1;
  localparam logic [NB_W-1:0] B_NB = NB_W'(B);

  logic [NB_W-1:0] n_eff;

  always_comb begin
    n_eff   = nbytes_i;
    data_o  = data_i;
    spill_o = 1'b0;
    if (nbytes_i == '0 || nbytes_i > B_NB) n_eff = B_NB;
    if (last_i) begin
      spill_o = (n_eff == B_NB);
      for (int i = 0; i < B; i++) begin
        if (NB_W'(i) == n_eff)     data_o[beat_w_g-1-8*i -: 8] = ASCON_PAD_BYTE;
        else if (NB_W'(i) > n_eff) data_o[beat_w_g-1-8*i -: 8] = 8'h00;
      end
    end
  end
endmodule

// File: rtl/ascon_block_loader.sv
// ascon_block_loader: packs beats into blocks with Ascon padding.
//   clock_i : rising-edge clock
//   reset_i : synchronous active-high reset
//   bus     : slave side of ascon_block_loader_if (beat in, block out)
// A block is held in S_HOLD until the consumer takes it; a message that ends
// exactly on a block boundary gets an extra pad-only block in S_PADBLK.
module ascon_block_loader
  import ascon_pack::*;
#(
  parameter int beat_w_g  = 32,
  parameter int block_w_g = 128
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  ascon_block_loader_if.slave  bus
);
  localparam int N     = block_w_g/beat_w_g;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [beat_w_g-1:0]  PAD_SLOT  = {ASCON_PAD_BYTE, {(beat_w_g-8){1'b0}}};
  localparam logic [block_w_g-1:0] PAD_BLOCK = {ASCON_PAD_BYTE, {(block_w_g-8){1'b0}}};

  loader_state_t        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 pad_pend_q;
  logic                 last_q, pad_q;
  logic [block_w_g-1:0] data_q;
  logic [beat_w_g-1:0]  beat_pad;
  logic                 spill;
  logic                 take;
  logic                 last_slot;

  ascon_beat_pad #(.beat_w_g(beat_w_g)) u_pad (
    .data_i   (bus.data_i),
    .last_i   (bus.last_i),
    .nbytes_i (bus.nbytes_i),
    .data_o   (beat_pad),
    .spill_o  (spill)
  );

  assign take      = bus.valid_i & bus.ready_o;
  assign last_slot = (cnt_q == CNT_W'(N-1));

  assign bus.en_o   = bus.block_valid_o & bus.block_ready_i;
  assign bus.data_o = data_q;
  assign bus.last_o = last_q;
  assign bus.pad_o  = pad_q;

  always_comb begin
    state_d           = state_q;
    bus.ready_o       = 1'b0;
    bus.block_valid_o = 1'b0;
    case (state_q)
      S_FILL: begin
        bus.ready_o = 1'b1;
        if (bus.valid_i && (bus.last_i || last_slot)) state_d = S_HOLD;
      end
      S_HOLD: begin
        bus.block_valid_o = 1'b1;
        if (bus.block_ready_i) state_d = pad_pend_q ? S_PADBLK : S_FILL;
      end
      S_PADBLK: begin
        bus.block_valid_o = 1'b1;
        if (bus.block_ready_i) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_FILL;
      cnt_q      <= '0;
      pad_pend_q <= 1'b0;
      last_q     <= 1'b0;
      pad_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FILL: if (take) begin
          // Slots above the current one are cleared as we go, so a short
          // message never exposes bytes from an earlier block.
          for (int s = 0; s < N; s++) begin
            if (CNT_W'(s) == cnt_q)
              data_q[block_w_g-1-s*beat_w_g -: beat_w_g] <= beat_pad;
            else if (CNT_W'(s) > cnt_q)
              data_q[block_w_g-1-s*beat_w_g -: beat_w_g] <=
                (bus.last_i && spill && CNT_W'(s) == cnt_q + 1'b1) ? PAD_SLOT : '0;
          end
          cnt_q <= (bus.last_i || last_slot) ? '0 : cnt_q + 1'b1;
          if (bus.last_i) begin
            if (spill && last_slot) begin
              pad_pend_q <= 1'b1;
            end else begin
              last_q <= 1'b1;
              pad_q  <= 1'b1;
            end
          end
        end
        S_HOLD: if (bus.block_ready_i) begin
          if (pad_pend_q) begin
            data_q     <= PAD_BLOCK;
            last_q     <= 1'b1;
            pad_q      <= 1'b1;
            pad_pend_q <= 1'b0;
          end else begin
            last_q <= 1'b0;
            pad_q  <= 1'b0;
          end
        end
        S_PADBLK: if (bus.block_ready_i) begin
          last_q <= 1'b0;
          pad_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_block_loader.sv
module tb_ascon_block_loader;
  logic clock_i = 1'b0;
  logic reset_i;
  int   errors = 0;
  int   checks = 0;

  always #5 clock_i = ~clock_i;

  ascon_block_loader_if #(.beat_w_g(32), .block_w_g(128)) bus ();
  ascon_block_loader #(.beat_w_g(32), .block_w_g(128)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  // Drive one beat at a falling edge and hold it until the loader takes it.
  task automatic send_beat(input logic [31:0] d, input logic l, input logic [2:0] nb);
    int w;
    @(negedge clock_i);
    bus.valid_i = 1'b1; bus.data_i = d; bus.last_i = l; bus.nbytes_i = nb;
    w = 0;
    while (!bus.ready_o && w < 2000) begin @(negedge clock_i); w++; end
    if (!bus.ready_o) begin
      checks++; errors++;
      $display("FAIL send_beat timeout: ready_o=%0b required 1", bus.ready_o);
    end else @(posedge clock_i);
    #1 bus.valid_i = 1'b0; bus.last_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clock_i);
    checks++; if (bus.data_o !== 128'h0)      begin errors++; $display("FAIL reset_data got %h want 0", bus.data_o); end
    checks++; if (bus.block_valid_o !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b want 0", bus.block_valid_o); end
    checks++; if (bus.en_o !== 1'b0)          begin errors++; $display("FAIL reset_en got %b want 0", bus.en_o); end
    checks++; if (bus.last_o !== 1'b0)        begin errors++; $display("FAIL reset_last got %b want 0", bus.last_o); end
    checks++; if (bus.pad_o !== 1'b0)         begin errors++; $display("FAIL reset_pad got %b want 0", bus.pad_o); end
    reset_i = 1'b0;
    @(negedge clock_i);
    checks++; if (bus.ready_o !== 1'b1)       begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
  endtask

  task automatic test_full_then_pad();
    bus.block_ready_i = 1'b1;
    send_beat(32'h00010203, 1'b0, 3'd4);
    send_beat(32'h04050607, 1'b0, 3'd4);
    send_beat(32'h08090A0B, 1'b0, 3'd4);
    send_beat(32'h0C0D0E0F, 1'b1, 3'd4);
    @(negedge clock_i);
    checks++;
    if (bus.en_o !== 1'b1 || bus.data_o !== 128'h000102030405060708090A0B0C0D0E0F ||
        bus.last_o !== 1'b0 || bus.pad_o !== 1'b0)
      begin errors++; $display("FAIL full_block got en=%b d=%h l=%b p=%b want en=1 d=000102..0f l=0 p=0",
                               bus.en_o, bus.data_o, bus.last_o, bus.pad_o); end
    @(negedge clock_i);
    checks++;
    if (bus.en_o !== 1'b1 || bus.data_o !== {8'h80, 120'h0} || bus.last_o !== 1'b1 || bus.pad_o !== 1'b1)
      begin errors++; $display("FAIL pad_block got en=%b d=%h l=%b p=%b want en=1 d=80..0 l=1 p=1",
                               bus.en_o, bus.data_o, bus.last_o, bus.pad_o); end
    @(negedge clock_i);
    checks++;
    if (bus.block_valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.last_o !== 1'b0)
      begin errors++; $display("FAIL after_pad got bv=%b rdy=%b l=%b want 0 1 0",
                               bus.block_valid_o, bus.ready_o, bus.last_o); end
  endtask

  task automatic test_partial_beat();
    send_beat(32'hAABBCCDD, 1'b1, 3'd2);
    @(negedge clock_i);
    checks++;
    if (bus.en_o !== 1'b1 || bus.data_o !== 128'hAABB8000_00000000_00000000_00000000 ||
        bus.last_o !== 1'b1 || bus.pad_o !== 1'b1)
      begin errors++; $display("FAIL partial_beat got en=%b d=%h l=%b p=%b want en=1 d=aabb8000.. l=1 p=1",
                               bus.en_o, bus.data_o, bus.last_o, bus.pad_o); end
    @(negedge clock_i);
    checks++;
    if (bus.block_valid_o !== 1'b0 || bus.last_o !== 1'b0 || bus.pad_o !== 1'b0)
      begin errors++; $display("FAIL partial_clear got bv=%b l=%b p=%b want 0 0 0",
                               bus.block_valid_o, bus.last_o, bus.pad_o); end
  endtask

  task automatic test_two_beats();
    send_beat(32'h11223344, 1'b0, 3'd4);
    send_beat(32'h55667788, 1'b1, 3'd4);
    @(negedge clock_i);
    checks++;
    if (bus.en_o !== 1'b1 || bus.data_o !== 128'h11223344_55667788_80000000_00000000 ||
        bus.last_o !== 1'b1 || bus.pad_o !== 1'b1)
      begin errors++; $display("FAIL two_beats got en=%b d=%h l=%b p=%b want en=1 d=11223344556677888000000000000000 l=1 p=1",
                               bus.en_o, bus.data_o, bus.last_o, bus.pad_o); end
    @(negedge clock_i);
    checks++;
    if (bus.block_valid_o !== 1'b0)
      begin errors++; $display("FAIL two_beats_single got bv=%b want 0", bus.block_valid_o); end
  endtask

  task automatic test_stall();
    logic [127:0] exp;
    exp = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    bus.block_ready_i = 1'b0;
    send_beat(32'h01234567, 1'b0, 3'd4);
    send_beat(32'h89ABCDEF, 1'b0, 3'd4);
    send_beat(32'hFEDCBA98, 1'b0, 3'd4);
    send_beat(32'h76543210, 1'b0, 3'd4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock_i);
      checks++;
      if (bus.block_valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.en_o !== 1'b0 || bus.data_o !== exp)
        begin errors++; $display("FAIL stall_%0d got bv=%b rdy=%b en=%b d=%h want 1 0 0 %h",
                                 c, bus.block_valid_o, bus.ready_o, bus.en_o, bus.data_o, exp); end
    end
    @(negedge clock_i);
    bus.block_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.en_o !== 1'b1 || bus.data_o !== exp || bus.last_o !== 1'b0)
      begin errors++; $display("FAIL stall_release got en=%b d=%h l=%b want 1 %h 0",
                               bus.en_o, bus.data_o, bus.last_o, exp); end
    @(negedge clock_i);
    checks++;
    if (bus.block_valid_o !== 1'b0 || bus.ready_o !== 1'b1)
      begin errors++; $display("FAIL stall_after got bv=%b rdy=%b want 0 1", bus.block_valid_o, bus.ready_o); end
  endtask

  task automatic test_reset_mid_block();
    send_beat(32'hDEADBEEF, 1'b0, 3'd4);
    send_beat(32'hCAFEF00D, 1'b0, 3'd4);
    @(negedge clock_i);
    reset_i = 1'b1;
    @(negedge clock_i);
    checks++;
    if (bus.data_o !== 128'h0 || bus.block_valid_o !== 1'b0 || bus.en_o !== 1'b0 ||
        bus.last_o !== 1'b0 || bus.pad_o !== 1'b0)
      begin errors++; $display("FAIL mid_reset got d=%h bv=%b en=%b l=%b p=%b want all 0",
                               bus.data_o, bus.block_valid_o, bus.en_o, bus.last_o, bus.pad_o); end
    reset_i = 1'b0;
    send_beat(32'h10203040, 1'b0, 3'd4);
    send_beat(32'h50607080, 1'b0, 3'd4);
    send_beat(32'h90A0B0C0, 1'b0, 3'd4);
    send_beat(32'hD0E0F0FF, 1'b1, 3'd3);
    @(negedge clock_i);
    checks++;
    if (bus.en_o !== 1'b1 || bus.data_o !== 128'h10203040_50607080_90A0B0C0_D0E0F080 ||
        bus.last_o !== 1'b1 || bus.pad_o !== 1'b1)
      begin errors++; $display("FAIL post_reset_block got en=%b d=%h l=%b p=%b want 1 10203040506070809 0a0b0c0d0e0f080 1 1",
                               bus.en_o, bus.data_o, bus.last_o, bus.pad_o); end
  endtask

  // Reference: message bytes, then 0x80, then zeros to a block multiple.
  // Final block carries last/pad; all earlier blocks carry neither.
  logic [127:0] exp_d[$];
  logic         exp_l[$];
  logic         exp_p[$];
  int           n_exp, n_got;
  bit           drv_done;

  task automatic drive_random();
    logic [2:0] oor [4];
    oor[0] = 3'd0; oor[1] = 3'd5; oor[2] = 3'd6; oor[3] = 3'd7;
    for (int m = 0; m < 1000; m++) begin
      int          nbeats, n, nblk;
      logic [2:0]  nbf;
      logic [7:0]  msg[$];
      logic [31:0] beats[$];
      nbeats = $urandom_range(1, 9);
      n      = $urandom_range(1, 4);
      nbf    = 3'(n);
      if (n == 4 && $urandom_range(0, 3) == 0) nbf = oor[$urandom_range(0, 3)];
      for (int b = 0; b < nbeats; b++) begin
        logic [31:0] bt;
        bt = '0;
        for (int j = 0; j < 4; j++) begin
          logic [7:0] v;
          v = 8'($urandom);
          if (b < nbeats-1 || j < n) msg.push_back(v);
          bt = {bt[23:0], v};
        end
        beats.push_back(bt);
      end
      msg.push_back(8'h80);
      while (msg.size() % 16 != 0) msg.push_back(8'h00);
      nblk = msg.size() / 16;
      for (int k = 0; k < nblk; k++) begin
        logic [127:0] blk;
        blk = '0;
        for (int j = 0; j < 16; j++) blk = {blk[119:0], msg[k*16+j]};
        exp_d.push_back(blk);
        exp_l.push_back(k == nblk-1);
        exp_p.push_back(k == nblk-1);
        n_exp++;
      end
      for (int b = 0; b < nbeats; b++) begin
        while ($urandom_range(0, 3) == 0) @(negedge clock_i);
        send_beat(beats[b], b == nbeats-1, (b == nbeats-1) ? nbf : 3'($urandom));
      end
    end
    drv_done = 1'b1;
  endtask

  task automatic monitor_random();
    int cyc;
    cyc = 0;
    while (!(drv_done && exp_d.size() == 0) && cyc < 60000) begin
      @(negedge clock_i);
      bus.block_ready_i = ($urandom_range(0, 2) != 0);
      #1;
      cyc++;
      if (bus.en_o === 1'b1) begin
        n_got++;
        checks++;
        if (exp_d.size() == 0) begin
          errors++; $display("FAIL rand_extra_block got d=%h want no block", bus.data_o);
        end else begin
          logic [127:0] d;
          logic         l, p;
          d = exp_d.pop_front(); l = exp_l.pop_front(); p = exp_p.pop_front();
          if (bus.data_o !== d || bus.last_o !== l || bus.pad_o !== p)
            begin errors++; $display("FAIL rand_block_%0d got d=%h l=%b p=%b want d=%h l=%b p=%b",
                                     n_got, bus.data_o, bus.last_o, bus.pad_o, d, l, p); end
        end
      end
    end
    if (cyc >= 60000) begin
      checks++; errors++;
      $display("FAIL rand_timeout got %0d blocks want %0d", n_got, n_exp);
    end
  endtask

  task automatic test_random();
    n_exp = 0; n_got = 0; drv_done = 1'b0;
    fork
      drive_random();
      monitor_random();
    join
    bus.block_ready_i = 1'b1;
    checks++;
    if (n_got !== n_exp)
      begin errors++; $display("FAIL rand_count got %0d blocks want %0d", n_got, n_exp); end
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.data_i = '0; bus.last_i = 1'b0; bus.nbytes_i = '0;
    bus.block_ready_i = 1'b1;
    reset_i = 1'b1;
    test_reset();
    test_full_then_pad();
    test_partial_beat();
    test_two_beats();
    test_stall();
    test_reset_mid_block();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
